// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute stage.
//   - XLEN_D / REG_AW_D : default datapath and register-index widths
//   - alu_op_e          : 4-bit ALU opcode carried in ALU_ctrl_in
package ex_pkg;

  localparam int XLEN_D   = 32;
  localparam int REG_AW_D = 5;

  // SLT doubles as the BLT compare and SLTU as BLTU; 4'hE is unassigned.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_SLL   = 4'h5,
    ALU_SRL   = 4'h6,
    ALU_SRA   = 4'h7,
    ALU_SLT   = 4'h8,
    ALU_SLTU  = 4'h9,
    ALU_EQ    = 4'hA,
    ALU_NE    = 4'hB,
    ALU_GE    = 4'hC,
    ALU_GEU   = 4'hD,
    ALU_PASSB = 4'hF
  } alu_op_e;

endpackage

// File: rtl/ex_stage_alu.sv
// alu: purely combinational ALU for the execute stage.
//   a, b   : operands (XLEN)
//   op     : alu_op_e opcode
//   result : XLEN result; compares return 0/1 in bit 0, unknown opcodes 0
module alu
  import ex_pkg::*;
#(
  parameter int XLEN = XLEN_D
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_e         op,
  output logic [XLEN-1:0] result
);

  logic [4:0] shamt;
  logic       lt_s, lt_u, eq;

  assign shamt = b[4:0];
  assign lt_s  = $signed(a) < $signed(b);
  assign lt_u  = a < b;
  assign eq    = a == b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, lt_u};
      ALU_EQ:    result = {{(XLEN-1){1'b0}}, eq};
      ALU_NE:    result = {{(XLEN-1){1'b0}}, ~eq};
      ALU_GE:    result = {{(XLEN-1){1'b0}}, ~lt_s};
      ALU_GEU:   result = {{(XLEN-1){1'b0}}, ~lt_u};
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with operand forwarding, ALU, branch/jump
// resolution and the EX/MEM pipeline register.
//   clk, reset     : clock, synchronous active-high reset
//   hold           : freeze EX/MEM register, suppress redirect
//   *_in           : ID/EX pipeline register contents
//   wb_*           : MEM/WB writeback bus used for forwarding
//   redirect(_pc)  : combinational PC redirect for taken branch / jump
//   *_out          : registered EX/MEM contents for the memory stage
module ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN   = XLEN_D,
  parameter int REG_AW = REG_AW_D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic [XLEN-1:0]   data_1_in,
  input  logic [XLEN-1:0]   data_2_in,
  input  logic [REG_AW-1:0] rs1_in,
  input  logic [REG_AW-1:0] rs2_in,
  input  logic [REG_AW-1:0] Rd_in,
  input  logic [3:0]        ALU_ctrl_in,
  input  logic              ALU_src_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic              auipc_in,
  input  logic [XLEN-1:0]   PC_in,
  input  logic              pc_src_in,
  input  logic              branch_in,
  input  logic              jump_in,
  input  logic              MEM_wen_in,
  input  logic              WB_sel_in,
  input  logic              Reg_WB_in,
  input  logic [REG_AW-1:0] wb_Rd,
  input  logic              wb_Reg_WB,
  input  logic [XLEN-1:0]   wb_data,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [XLEN-1:0]   alu_result_out,
  output logic [XLEN-1:0]   store_data_out,
  output logic [REG_AW-1:0] Rd_out,
  output logic              MEM_wen_out,
  output logic              WB_sel_out,
  output logic              Reg_WB_out
);

  logic [XLEN-1:0] fwd_1, fwd_2, op_a, op_b, alu_res, tgt_sum;
  logic            exm_ok, wb_ok, taken;

  // A load in EX/MEM has no data yet; the hazard unit stalls for that case.
  assign exm_ok = Reg_WB_out & ~WB_sel_out & (Rd_out != '0);
  assign wb_ok  = wb_Reg_WB & (wb_Rd != '0);

  always_comb begin
    fwd_1 = data_1_in;
    if (exm_ok && Rd_out == rs1_in)     fwd_1 = alu_result_out;
    else if (wb_ok && wb_Rd == rs1_in)  fwd_1 = wb_data;
    fwd_2 = data_2_in;
    if (exm_ok && Rd_out == rs2_in)     fwd_2 = alu_result_out;
    else if (wb_ok && wb_Rd == rs2_in)  fwd_2 = wb_data;
  end

  assign op_a = auipc_in   ? PC_in  : fwd_1;
  assign op_b = ALU_src_in ? imm_in : fwd_2;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .op     (alu_op_e'(ALU_ctrl_in)),
    .result (alu_res)
  );

  // Replayed instruction under hold must not redirect twice.
  assign taken       = branch_in & alu_res[0];
  assign redirect    = (jump_in | taken) & ~hold & ~reset;
  assign tgt_sum     = (pc_src_in ? PC_in : fwd_1) + imm_in;
  assign redirect_pc = {tgt_sum[XLEN-1:1], tgt_sum[0] & pc_src_in};

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_result_out <= '0;
      store_data_out <= '0;
      Rd_out         <= '0;
      MEM_wen_out    <= 1'b0;
      WB_sel_out     <= 1'b0;
      Reg_WB_out     <= 1'b0;
    end else if (!hold) begin
      alu_result_out <= jump_in ? PC_in + XLEN'(4) : alu_res;
      store_data_out <= fwd_2;
      Rd_out         <= Rd_in;
      MEM_wen_out    <= MEM_wen_in;
      WB_sel_out     <= WB_sel_in;
      Reg_WB_out     <= Reg_WB_in;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: table-driven self-checking bench for ex_stage. Each row holds
// ID/EX + MEM/WB inputs and hand-derived expected results; registered
// expectations go through a scoreboard queue and are popped after the edge.
module tb_ex_stage;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        reset, hold;
  logic [31:0] data_1_in, data_2_in, imm_in, PC_in, wb_data;
  logic [4:0]  rs1_in, rs2_in, Rd_in, wb_Rd;
  logic [3:0]  ALU_ctrl_in;
  logic        ALU_src_in, auipc_in, pc_src_in, branch_in, jump_in;
  logic        MEM_wen_in, WB_sel_in, Reg_WB_in, wb_Reg_WB;
  logic        redirect, MEM_wen_out, WB_sel_out, Reg_WB_out;
  logic [31:0] redirect_pc, alu_result_out, store_data_out;
  logic [4:0]  Rd_out;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .reset(reset), .hold(hold),
    .data_1_in(data_1_in), .data_2_in(data_2_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .Rd_in(Rd_in),
    .ALU_ctrl_in(ALU_ctrl_in), .ALU_src_in(ALU_src_in), .imm_in(imm_in),
    .auipc_in(auipc_in), .PC_in(PC_in), .pc_src_in(pc_src_in),
    .branch_in(branch_in), .jump_in(jump_in), .MEM_wen_in(MEM_wen_in),
    .WB_sel_in(WB_sel_in), .Reg_WB_in(Reg_WB_in),
    .wb_Rd(wb_Rd), .wb_Reg_WB(wb_Reg_WB), .wb_data(wb_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out),
    .Rd_out(Rd_out), .MEM_wen_out(MEM_wen_out),
    .WB_sel_out(WB_sel_out), .Reg_WB_out(Reg_WB_out)
  );

  typedef struct {
    logic        hold;
    logic [31:0] d1, d2, imm, pc, wbdata;
    logic [4:0]  rs1, rs2, rd, wbrd;
    logic [3:0]  op;
    logic        src, auipc, pcsrc, br, jmp, wen, wbsel, regwb, wbreg;
    logic [31:0] exp_alu, exp_st, exp_rpc;
    logic        exp_redir;
  } vec_t;

  typedef struct {
    logic [31:0] alu, st;
    logic [4:0]  rd;
    logic        wen, wbsel, regwb;
  } exp_t;

  vec_t  tbl[$];
  exp_t  sb[$];
  exp_t  last;
  int    npass = 0, ntotal = 0;
  string tag;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s %s: got 0x%08h expected 0x%08h", tag, name, act, exp);
  endtask

  function automatic vec_t nv();
    vec_t v;
    v.hold = 0; v.d1 = 0; v.d2 = 0; v.imm = 0; v.pc = 0; v.wbdata = 0;
    v.rs1 = 0; v.rs2 = 0; v.rd = 0; v.wbrd = 0; v.op = 0;
    v.src = 0; v.auipc = 0; v.pcsrc = 0; v.br = 0; v.jmp = 0;
    v.wen = 0; v.wbsel = 0; v.regwb = 0; v.wbreg = 0;
    v.exp_alu = 0; v.exp_st = 0; v.exp_rpc = 0; v.exp_redir = 0;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    hold = v.hold; data_1_in = v.d1; data_2_in = v.d2; imm_in = v.imm;
    PC_in = v.pc; wb_data = v.wbdata; rs1_in = v.rs1; rs2_in = v.rs2;
    Rd_in = v.rd; wb_Rd = v.wbrd; ALU_ctrl_in = v.op; ALU_src_in = v.src;
    auipc_in = v.auipc; pc_src_in = v.pcsrc; branch_in = v.br;
    jump_in = v.jmp; MEM_wen_in = v.wen; WB_sel_in = v.wbsel;
    Reg_WB_in = v.regwb; wb_Reg_WB = v.wbreg;
  endtask

  task automatic check_regs();
    exp_t e;
    if (sb.size() == 0) begin
      ntotal++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk("alu_result_out", alu_result_out, e.alu);
    chk("store_data_out", store_data_out, e.st);
    chk("Rd_out", {27'd0, Rd_out}, {27'd0, e.rd});
    chk("MEM_wen_out", {31'd0, MEM_wen_out}, {31'd0, e.wen});
    chk("WB_sel_out", {31'd0, WB_sel_out}, {31'd0, e.wbsel});
    chk("Reg_WB_out", {31'd0, Reg_WB_out}, {31'd0, e.regwb});
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    drive(v);
    #1;
    chk("redirect", {31'd0, redirect}, {31'd0, v.exp_redir});
    if (v.exp_redir) chk("redirect_pc", redirect_pc, v.exp_rpc);
    if (v.hold) e = last;
    else begin
      e.alu = v.exp_alu; e.st = v.exp_st; e.rd = v.rd;
      e.wen = v.wen; e.wbsel = v.wbsel; e.regwb = v.regwb;
    end
    sb.push_back(e);
    last = e;
    @(posedge clk); #1;
    check_regs();
  endtask

  // Reset with hold high and live inputs: reset wins, no redirect.
  task automatic reset_seq(input string name);
    exp_t z;
    vec_t v;
    tag = name;
    z.alu = 0; z.st = 0; z.rd = 0; z.wen = 0; z.wbsel = 0; z.regwb = 0;
    @(negedge clk);
    v = nv(); v.hold = 1; v.d1 = 32'h1234; v.d2 = 32'h5678; v.rd = 5'd7;
    v.regwb = 1; v.wen = 1; v.wbsel = 1; v.jmp = 1; v.br = 1; v.pc = 32'h80;
    drive(v);
    reset = 1;
    #1;
    chk("redirect_in_reset", {31'd0, redirect}, 32'd0);
    sb.push_back(z);
    last = z;
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    vec_t v;
    reset = 1;
    drive(nv());
    // 0 ADD x3 = x1 + x2
    v = nv(); v.d1 = 5; v.d2 = 7; v.rs1 = 1; v.rs2 = 2; v.rd = 3; v.regwb = 1;
    v.exp_alu = 12; v.exp_st = 7; tbl.push_back(v);
    // 1 SUB x4 = x3 - x1, x3 from EX/MEM
    v = nv(); v.d1 = 100; v.d2 = 5; v.rs1 = 3; v.rs2 = 1; v.rd = 4; v.regwb = 1;
    v.op = ALU_SUB; v.exp_alu = 7; v.exp_st = 5; tbl.push_back(v);
    // 2 EX/MEM and MEM/WB both match rs1: EX/MEM wins
    v = nv(); v.d1 = 50; v.d2 = 1; v.rs1 = 4; v.rs2 = 0; v.rd = 5; v.regwb = 1;
    v.wbrd = 4; v.wbreg = 1; v.wbdata = 9; v.exp_alu = 8; v.exp_st = 1; tbl.push_back(v);
    // 3 MEM/WB forward on rs2 (also store data)
    v = nv(); v.d1 = 2; v.d2 = 32'h11; v.rs2 = 9; v.rd = 6; v.regwb = 1;
    v.wbrd = 9; v.wbreg = 1; v.wbdata = 32'h33; v.exp_alu = 32'h35; v.exp_st = 32'h33; tbl.push_back(v);
    // 4 LUI-style PASSB into x0 with Reg_WB set
    v = nv(); v.op = ALU_PASSB; v.src = 1; v.imm = 32'hDEAD; v.regwb = 1;
    v.exp_alu = 32'hDEAD; tbl.push_back(v);
    // 5 index 0 never forwards (EX/MEM rd=0, MEM/WB rd=0)
    v = nv(); v.d1 = 32'h11; v.d2 = 32'h22; v.rd = 7; v.regwb = 1;
    v.wbreg = 1; v.wbdata = 32'h99; v.exp_alu = 32'h33; v.exp_st = 32'h22; tbl.push_back(v);
    // 6 load (WB_sel=1) address calc
    v = nv(); v.d1 = 32'h1000; v.rs1 = 1; v.src = 1; v.imm = 4; v.rd = 8;
    v.regwb = 1; v.wbsel = 1; v.exp_alu = 32'h1004; tbl.push_back(v);
    // 7 load in EX/MEM does not forward
    v = nv(); v.d1 = 32'h20; v.d2 = 3; v.rs1 = 8; v.rs2 = 2; v.rd = 9; v.regwb = 1;
    v.exp_alu = 32'h23; v.exp_st = 3; tbl.push_back(v);
    // 8.. ALU op sweep, sources not forwarded
    v = nv(); v.op = ALU_AND; v.d1 = 32'hF0F0; v.d2 = 32'hFF00; v.rs1 = 10; v.rs2 = 11;
    v.exp_alu = 32'hF000; v.exp_st = 32'hFF00; tbl.push_back(v);
    v = nv(); v.op = ALU_SRA; v.d1 = 32'h8000_0000; v.d2 = 4; v.rs1 = 12; v.rs2 = 13;
    v.exp_alu = 32'hF800_0000; v.exp_st = 4; tbl.push_back(v);
    v = nv(); v.op = ALU_SRL; v.d1 = 32'h8000_0000; v.d2 = 4;
    v.exp_alu = 32'h0800_0000; v.exp_st = 4; tbl.push_back(v);
    v = nv(); v.op = ALU_SLT; v.d1 = 32'hFFFF_FFFF; v.d2 = 1; v.exp_alu = 1; v.exp_st = 1; tbl.push_back(v);
    v = nv(); v.op = ALU_SLTU; v.d1 = 32'hFFFF_FFFF; v.d2 = 1; v.exp_alu = 0; v.exp_st = 1; tbl.push_back(v);
    v = nv(); v.op = ALU_SLL; v.d1 = 1; v.d2 = 32'h23; v.exp_alu = 8; v.exp_st = 32'h23; tbl.push_back(v);
    v = nv(); v.op = ALU_XOR; v.d1 = 32'hFF; v.d2 = 32'h0F; v.exp_alu = 32'hF0; v.exp_st = 32'h0F; tbl.push_back(v);
    v = nv(); v.op = ALU_OR; v.d1 = 32'hF0; v.d2 = 32'h0F; v.exp_alu = 32'hFF; v.exp_st = 32'h0F; tbl.push_back(v);
    v = nv(); v.op = ALU_SUB; v.d1 = 0; v.d2 = 1; v.exp_alu = 32'hFFFF_FFFF; v.exp_st = 1; tbl.push_back(v);
    v = nv(); v.op = 4'hE; v.d1 = 32'h55; v.d2 = 32'h66; v.exp_alu = 0; v.exp_st = 32'h66; tbl.push_back(v);
    v = nv(); v.op = ALU_GE; v.d1 = 32'hFFFF_FFFF; v.d2 = 1; v.exp_alu = 0; v.exp_st = 1; tbl.push_back(v);
    v = nv(); v.op = ALU_GEU; v.d1 = 32'hFFFF_FFFF; v.d2 = 1; v.exp_alu = 1; v.exp_st = 1; tbl.push_back(v);
    // BEQ taken, BNE not taken
    v = nv(); v.op = ALU_EQ; v.br = 1; v.d1 = 32'h10; v.d2 = 32'h10; v.rs1 = 14; v.rs2 = 15;
    v.pc = 32'h100; v.imm = 32'h20; v.pcsrc = 1;
    v.exp_alu = 1; v.exp_st = 32'h10; v.exp_redir = 1; v.exp_rpc = 32'h120; tbl.push_back(v);
    v.op = ALU_NE; v.exp_alu = 0; v.exp_redir = 0; tbl.push_back(v);
    // JALR: odd target has bit 0 cleared, link = PC+4
    v = nv(); v.jmp = 1; v.d1 = 32'h203; v.rs1 = 16; v.d2 = 32'hAB; v.rs2 = 17;
    v.src = 1; v.imm = 4; v.pc = 32'h40; v.rd = 1; v.regwb = 1;
    v.exp_alu = 32'h44; v.exp_st = 32'hAB; v.exp_redir = 1; v.exp_rpc = 32'h206; tbl.push_back(v);
    // AUIPC store: operand A = PC, store data forwarded from EX/MEM x1
    v = nv(); v.auipc = 1; v.pc = 32'h1000; v.src = 1; v.imm = 32'h5000; v.rs1 = 1;
    v.rs2 = 1; v.rd = 2; v.wen = 1; v.exp_alu = 32'h6000; v.exp_st = 32'h44; tbl.push_back(v);
    // hold for 3 cycles with changing inputs including a jump and taken branch
    v = nv(); v.hold = 1; v.jmp = 1; v.pcsrc = 1; v.pc = 32'h300; v.imm = 8; v.rd = 5; v.regwb = 1;
    tbl.push_back(v);
    v = nv(); v.hold = 1; v.br = 1; v.op = ALU_EQ; v.d1 = 3; v.d2 = 3; v.pcsrc = 1; v.wen = 1;
    tbl.push_back(v);
    v = nv(); v.hold = 1; v.d1 = 32'h77; v.d2 = 32'h88; v.rd = 9; v.wbsel = 1; v.regwb = 1;
    tbl.push_back(v);
    // release: new result captured
    v = nv(); v.d1 = 1; v.d2 = 2; v.rs1 = 20; v.rs2 = 21; v.rd = 3; v.regwb = 1;
    v.exp_alu = 3; v.exp_st = 2; tbl.push_back(v);
    // bubble
    v = nv(); v.pcsrc = 1; tbl.push_back(v);
    // JAL with PC base keeps bit 0 of target
    v = nv(); v.jmp = 1; v.pcsrc = 1; v.pc = 32'h80; v.imm = 32'h11;
    v.exp_alu = 32'h84; v.exp_redir = 1; v.exp_rpc = 32'h91; tbl.push_back(v);

    repeat (2) @(posedge clk);
    reset_seq("reset_initial");
    for (int i = 0; i < tbl.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      apply(tbl[i]);
    end
    reset_seq("reset_midrun");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
